// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - parametrised multi-channel reset sequencer
//
// Holds every reset channel asserted for HOLD_CYCLES after any reset cause,
// waits for LOCK_FILTER consecutive cycles of lock_in, then releases the
// channels one at a time in ascending index order, each after its own delay.
//
// Ports:
//   sys_clk        in   sole clock
//   sys_rst        in   synchronous active-high reset
//   trigger_reset  in   level-sensitive software/button reset request
//   lock_in        in   combined PLL/DCM lock, already in sys_clk domain
//   rst_out        out  per-channel resets, polarity selected by INV_MASK
//   stage          out  number of channels released so far
//   done           out  high once every channel is released
module rst_sequencer #(
    parameter int                   N_OUT       = 4,
    parameter int                   CW          = 20,
    parameter logic [CW-1:0]        HOLD_CYCLES = {CW{1'b1}},
    parameter int                   LOCK_FILTER = 16,
    parameter logic [N_OUT*CW-1:0]  DELAYS      = {N_OUT{CW'(128)}},
    parameter logic [N_OUT-1:0]     INV_MASK    = '0,
    localparam int                  SW          = $clog2(N_OUT + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             trigger_reset,
    input  logic             lock_in,
    output logic [N_OUT-1:0] rst_out,
    output logic [SW-1:0]    stage,
    output logic             done
);

    if (HOLD_CYCLES == '0) begin : g_bad_hold
        $error("rst_sequencer: HOLD_CYCLES must be nonzero");
    end
    if (LOCK_FILTER < 1) begin : g_bad_filter
        $error("rst_sequencer: LOCK_FILTER must be at least 1");
    end
    if (N_OUT < 1 || N_OUT > 16) begin : g_bad_nout
        $error("rst_sequencer: N_OUT must be in 1..16");
    end

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_SEQ       = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_OUT - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_filt;
    logic [N_OUT-1:0] r_a;      // internal assert vector, 1 = channel held in reset
    logic [SW-1:0]    r_stage;
    logic             r_done;

    logic [CW-1:0]    w_next_delay;
    logic             w_abort;

    // Delay for the channel after the one currently being released.
    always_comb begin
        w_next_delay = '0;
        for (int i = 1; i < N_OUT; i++) begin
            if (r_stage == SW'(i - 1)) begin
                w_next_delay = DELAYS[i*CW +: CW];
            end
        end
    end

    // sys_rst, trigger_reset and lock loss all perform the same reload, so
    // their relative priority collapses into a single OR. Lock loss only
    // counts once sequencing has begun; before that the filter handles it.
    assign w_abort = sys_rst | trigger_reset |
                     (~lock_in & ((r_state == ST_SEQ) | (r_state == ST_RUN)));

    always_ff @(posedge sys_clk) begin
        if (w_abort) begin
            r_state <= ST_ASSERT;
            r_a     <= '1;
            r_cnt   <= HOLD_CYCLES - 1'b1;
            r_filt  <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_WAIT_LOCK;
                        r_filt  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!lock_in) begin
                        r_filt <= '0;
                    end else if (r_filt == FILT_LAST) begin
                        r_state <= ST_SEQ;
                        r_cnt   <= DELAYS[0 +: CW];
                        r_stage <= '0;
                    end else begin
                        r_filt <= r_filt + 1'b1;
                    end
                end
                ST_SEQ: begin
                    if (r_cnt == '0) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (r_stage == SW'(i)) begin
                                r_a[i] <= 1'b0;
                            end
                        end
                        r_stage <= r_stage + 1'b1;
                        if (r_stage == STAGE_LAST) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= w_next_delay;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a    <= '0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_ASSERT;
                    r_a     <= '1;
                    r_cnt   <= HOLD_CYCLES - 1'b1;
                end
            endcase
        end
    end

    assign rst_out = r_a ^ INV_MASK;
    assign stage   = r_stage;
    assign done    = r_done;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer
module tb_rst_sequencer;

    localparam int          N    = 3;
    localparam int          CW   = 20;
    localparam int          HOLD = 8;
    localparam int          LF   = 4;
    localparam int          D0   = 3;
    localparam int          D1   = 0;
    localparam int          D2   = 5;
    localparam logic [2:0]  INV  = 3'b001;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       trigger_reset;
    logic       lock_in;
    logic [2:0] rst_out;
    logic [1:0] stage;
    logic       done;

    rst_sequencer #(
        .N_OUT       (N),
        .CW          (CW),
        .HOLD_CYCLES (20'(HOLD)),
        .LOCK_FILTER (LF),
        .DELAYS      ({20'(D2), 20'(D1), 20'(D0)}),
        .INV_MASK    (INV)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .trigger_reset (trigger_reset),
        .lock_in       (lock_in),
        .rst_out       (rst_out),
        .stage         (stage),
        .done          (done)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected output after each edge: {rst_out, stage, done}
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: timeline of edges. Channel i is released at edge
    // seq_start + sum_{j<=i}(D[j]+1); sequencing starts on the edge where
    // LF consecutive lock-high samples have been seen after the hold.
    int m_n        = 0;
    int m_abort    = 0;
    bit m_seq      = 0;
    int m_seq_start = 0;
    int m_run      = 0;
    int rel_off[N];

    task automatic model_step(input bit s, input bit t, input bit l);
        logic [2:0] e_rst;
        int         e_cnt;
        bit         rel;
        m_n++;
        if (s || t || (m_seq && !l && m_n > m_seq_start)) begin
            m_abort = m_n;
            m_seq   = 0;
            m_run   = 0;
        end else if (!m_seq && m_n > m_abort + HOLD) begin
            m_run = l ? m_run + 1 : 0;
            if (m_run == LF) begin
                m_seq       = 1;
                m_seq_start = m_n;
            end
        end
        e_cnt = 0;
        for (int i = 0; i < N; i++) begin
            rel      = m_seq && (m_n >= m_seq_start + rel_off[i]);
            e_rst[i] = (~rel) ^ INV[i];
            e_cnt   += rel ? 1 : 0;
        end
        exp_q.push_back({e_rst, 2'(e_cnt), e_cnt == N});
    endtask

    task automatic cyc(input bit s, input bit t, input bit l);
        sys_rst       = s;
        trigger_reset = t;
        lock_in       = l;
        @(posedge sys_clk);
        model_step(s, t, l);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one output word per edge, compared on the falling edge.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("no_x",    8'($isunknown({rst_out, stage, done})), 8'd0);
                chk("rst_out", 8'(rst_out), 8'(e[5:3]));
                chk("stage",   8'(stage),   8'(e[2:1]));
                chk("done",    8'(done),    8'(e[0]));
            end
        end
    end

    initial begin
        int off;
        int dl[N];
        dl  = '{D0, D1, D2};
        off = 0;
        for (int i = 0; i < N; i++) begin
            off       += dl[i] + 1;
            rel_off[i] = off;
        end

        sys_rst = 1'b1; trigger_reset = 1'b0; lock_in = 1'b1;

        // Plain power-up sequence through to RUN.
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        repeat (30) cyc(0, 0, 1);

        // Lock glitch during WAIT_LOCK at filt=2.
        cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (30) cyc(0, 0, 1);

        // Single-cycle lock loss in RUN.
        cyc(0, 0, 0);
        repeat (30) cyc(0, 0, 1);

        // trigger_reset held 10 cycles after ch0 release, before ch1.
        cyc(1, 0, 1);
        repeat (16) cyc(0, 0, 1);
        repeat (10) cyc(0, 1, 1);
        repeat (35) cyc(0, 0, 1);

        // sys_rst + trigger_reset with lock low while in RUN.
        cyc(1, 1, 0);
        repeat (30) cyc(0, 0, 1);

        // Random stimulus.
        repeat (400) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 47) == 0,
                $urandom_range(0, 19) != 0);
        end

        @(negedge sys_clk);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
